// File: rtl/bid_assembler.sv
// bid_assembler
//   Feeds the 10-way argmax winner stage. Collects one round of bids from a
//   valid/ready stream into a 10-entry register array (bids), waits out the
//   argmax latency, then captures the winner index and winning bid and offers
//   them downstream on a valid/ready handshake.
//
//   Parameters: bW      bid width (must match the argmax stage)
//               RESERVE reserve price, active only with BID_RESERVE_EN
//   Ports:      clk, rst (sync, active high)
//               in_valid/in_ready/in_id/in_bid/in_last   bid beat stream
//               bids[0:9]                                array to argmax
//               win_in                                   argmax winner index
//               out_valid/out_ready/out_winner/out_bid/out_err/out_none
//   Optional:   define BID_RESERVE_EN to enable reserve-price filtering and
//               the out_none flag (otherwise out_none is tied to 0).
//
//   state   | meaning
//   COLLECT | accepting beats, building the bid array
//   SETTLE  | array frozen; argmax samples it, then win_in is valid
//   PRESENT | result held on out_* until out_ready
module bid_assembler #(
  parameter int unsigned     bW      = 17,
  parameter logic [bW-1:0]   RESERVE = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    in_id,
  input  logic [bW-1:0] in_bid,
  input  logic          in_last,
  output logic [bW-1:0] bids [0:9],
  input  logic [3:0]    win_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [3:0]    out_winner,
  output logic [bW-1:0] out_bid,
  output logic          out_err,
  output logic          out_none
);

  typedef enum logic [1:0] {COLLECT, SETTLE, PRESENT} state_t;

`ifdef BID_RESERVE_EN
  localparam bit RES_EN = 1'b1;
`else
  localparam bit RES_EN = 1'b0;
`endif

  state_t        state, state_nxt;
  logic [9:0]    rcvd;
  logic          err_q;
  logic          settle_cnt;
  logic          accept;
  logic          capture;
  logic [bW-1:0] bid_eff;

  assign accept  = in_valid && in_ready;
  assign capture = (state == SETTLE) && !settle_cnt;
  // Bids under the reserve are stored as 0 but still count as received.
  assign bid_eff = (RES_EN && (in_bid < RESERVE)) ? '0 : in_bid;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= COLLECT;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      COLLECT: if (accept && in_last) state_nxt = SETTLE;
      SETTLE:  if (!settle_cnt)       state_nxt = PRESENT;
      PRESENT: if (out_ready)         state_nxt = COLLECT;
      default:                        state_nxt = COLLECT;
    endcase
  end

  // Outputs; in_ready is also held low while rst is asserted so no beat
  // is offered acceptance during reset.
  always_comb begin
    in_ready  = (state == COLLECT) && !rst;
    out_valid = (state == PRESENT);
  end

  // Bid array, received mask, error flag and result capture
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 10; i++) bids[i] <= '0;
      rcvd       <= '0;
      err_q      <= 1'b0;
      settle_cnt <= 1'b0;
      out_winner <= '0;
      out_bid    <= '0;
      out_err    <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          if (accept) begin
            if (in_id > 4'd9) err_q <= 1'b1;
            for (int i = 0; i < 10; i++) begin
              if (in_id == 4'(i)) begin
                if (bid_eff > bids[i]) bids[i] <= bid_eff;
                if (rcvd[i]) err_q <= 1'b1;
                rcvd[i] <= 1'b1;
              end
            end
            if (in_last) settle_cnt <= 1'b1;
          end
        end
        SETTLE: begin
          if (settle_cnt) begin
            settle_cnt <= 1'b0;
          end else begin
            out_winner <= win_in;
            out_err    <= err_q;
            // An out-of-range win_in selects nothing and yields 0.
            out_bid    <= '0;
            for (int i = 0; i < 10; i++)
              if (win_in == 4'(i)) out_bid <= bids[i];
          end
        end
        PRESENT: begin
          if (out_ready) begin
            for (int i = 0; i < 10; i++) bids[i] <= '0;
            rcvd  <= '0;
            err_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef BID_RESERVE_EN
  logic all_zero;

  always_comb begin
    all_zero = 1'b1;
    for (int i = 0; i < 10; i++)
      if (bids[i] != '0) all_zero = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst)          out_none <= 1'b0;
    else if (capture) out_none <= all_zero;
  end
`else
  assign out_none = 1'b0;
`endif

endmodule

// File: tb/tb_bid_assembler.sv
module tb_bid_assembler;
  localparam int unsigned   BW   = 17;
  localparam logic [BW-1:0] RESV = 17'd16;

  typedef struct {
    logic [3:0]    w;
    logic [BW-1:0] b;
    logic          e;
    logic          n;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    in_id = '0;
  logic [BW-1:0] in_bid = '0;
  logic          in_last = 1'b0;
  logic [BW-1:0] bids [0:9];
  logic [3:0]    win_in;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [3:0]    out_winner;
  logic [BW-1:0] out_bid;
  logic          out_err;
  logic          out_none;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int acc_cyc = 0;
  exp_t sb[$];

  logic [BW-1:0] mdl [10];
  logic [BW-1:0] last_mdl [10];
  logic [9:0]    mmask = '0;
  bit            merr = 1'b0;

  bid_assembler #(.bW(BW), .RESERVE(RESV)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_id(in_id),
    .in_bid(in_bid), .in_last(in_last),
    .bids(bids), .win_in(win_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_winner(out_winner), .out_bid(out_bid),
    .out_err(out_err), .out_none(out_none)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Argmax stage stand-in: registered, lowest index wins ties.
  function automatic logic [3:0] amax();
    logic [3:0] w;
    w = '0;
    for (int i = 1; i < 10; i++) if (bids[i] > bids[w]) w = 4'(i);
    return w;
  endfunction

  always @(posedge clk) begin
    if (rst) win_in <= '0;
    else     win_in <= amax();
  end

  initial begin
    #500000;
    $display("FAIL watchdog: sim time exceeded, required finish");
    $fatal(1, "watchdog");
  end

  task automatic model_clear();
    for (int i = 0; i < 10; i++) mdl[i] = '0;
    mmask = '0;
    merr  = 1'b0;
  endtask

  // Drives one beat (called at negedge, returns at negedge after acceptance)
  // and updates the reference model; a last beat pushes the expected result.
  task automatic drive_beat(input logic [3:0] id, input logic [BW-1:0] b, input bit last);
    logic [BW-1:0] eff;
    exp_t e;
    int n;
    in_valid = 1'b1; in_id = id; in_bid = b; in_last = last;
    n = 0;
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL beat_accept: in_ready=%0b required 1 within 20 cycles", in_ready);
      in_valid = 1'b0;
      return;
    end
    acc_cyc = cyc;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
`ifdef BID_RESERVE_EN
    eff = (b < RESV) ? '0 : b;
`else
    eff = b;
`endif
    if (id > 4'd9) merr = 1'b1;
    else begin
      if (mmask[id]) merr = 1'b1;
      mmask[id] = 1'b1;
      if (eff > mdl[id]) mdl[id] = eff;
    end
    if (last) begin
      e.w = '0;
      for (int i = 1; i < 10; i++) if (mdl[i] > mdl[e.w]) e.w = 4'(i);
      e.b = mdl[e.w];
      e.e = merr;
      e.n = 1'b0;
`ifdef BID_RESERVE_EN
      e.n = 1'b1;
      for (int i = 0; i < 10; i++) if (mdl[i] != '0) e.n = 1'b0;
`endif
      sb.push_back(e);
      for (int i = 0; i < 10; i++) last_mdl[i] = mdl[i];
      model_clear();
    end
  endtask

  task automatic get_result(output bit ok);
    int n;
    n = 0;
    while (!out_valid && n < 60) begin @(negedge clk); n++; end
    ok = out_valid;
  endtask

  task automatic ack();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    bit nz;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    nz = 1'b0;
    for (int i = 0; i < 10; i++) if (bids[i] !== '0) nz = 1'b1;
    checks += 3;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %0b required 0", in_ready); end
    if (nz) begin errors++; $display("FAIL reset_bids: nonzero entry, required all 0"); end
    if ({out_valid, out_winner, out_bid, out_err, out_none} !== '0)
      begin errors++; $display("FAIL reset_outputs: valid=%0b win=%0d bid=%0d err=%0b none=%0b required all 0", out_valid, out_winner, out_bid, out_err, out_none); end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %0b required 1", in_ready); end
  endtask

  task automatic test_basic();
    exp_t e; bit ok;
    drive_beat(4'd0, 17'd10, 1'b0);
    drive_beat(4'd1, 17'd40, 1'b0);
    drive_beat(4'd2, 17'd25, 1'b1);
    checks += 3;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_lat_e0: out_valid=%0b required 0", out_valid); end
    @(negedge clk);
    if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_lat_e1: out_valid=%0b required 0", out_valid); end
    @(negedge clk);
    if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_lat_e2: out_valid=%0b required 1", out_valid); end
    get_result(ok);
    e = sb.pop_front();
    checks += 4;
    if (!ok) begin errors++; $display("FAIL basic_valid: out_valid=%0b required 1", out_valid); end
    if (out_winner !== e.w) begin errors++; $display("FAIL basic_winner: got %0d required %0d", out_winner, e.w); end
    if (out_bid !== e.b) begin errors++; $display("FAIL basic_bid: got %0d required %0d", out_bid, e.b); end
    if (out_err !== e.e) begin errors++; $display("FAIL basic_err: got %0b required %0b", out_err, e.e); end
    ack();
  endtask

  task automatic test_duplicate();
    exp_t e; bit ok;
    for (int r = 0; r < 2; r++) begin
      drive_beat(4'd9, (r == 0) ? 17'd7 : 17'd50, 1'b0);
      drive_beat(4'd9, (r == 0) ? 17'd30 : 17'd20, 1'b1);
      get_result(ok);
      e = sb.pop_front();
      checks += 5;
      if (!ok) begin errors++; $display("FAIL dup_valid r%0d: out_valid=%0b required 1", r, out_valid); end
      if (bids[9] !== last_mdl[9]) begin errors++; $display("FAIL dup_bids9 r%0d: got %0d required %0d", r, bids[9], last_mdl[9]); end
      if (out_winner !== e.w) begin errors++; $display("FAIL dup_winner r%0d: got %0d required %0d", r, out_winner, e.w); end
      if (out_bid !== e.b) begin errors++; $display("FAIL dup_bid r%0d: got %0d required %0d", r, out_bid, e.b); end
      if (out_err !== e.e) begin errors++; $display("FAIL dup_err r%0d: got %0b required %0b", r, out_err, e.e); end
      ack();
    end
  endtask

  task automatic test_illegal();
    exp_t e; bit ok, nz;
    drive_beat(4'd12, 17'd99, 1'b1);
    get_result(ok);
    e = sb.pop_front();
    nz = 1'b0;
    for (int i = 0; i < 10; i++) if (bids[i] !== '0) nz = 1'b1;
    checks += 4;
    if (!ok) begin errors++; $display("FAIL illegal_valid: out_valid=%0b required 1", out_valid); end
    if (nz) begin errors++; $display("FAIL illegal_bids: nonzero entry, required all 0"); end
    if (out_bid !== e.b) begin errors++; $display("FAIL illegal_bid: got %0d required %0d", out_bid, e.b); end
    if (out_err !== e.e) begin errors++; $display("FAIL illegal_err: got %0b required %0b", out_err, e.e); end
    ack();
  endtask

  task automatic test_backpressure();
    exp_t e; bit ok;
    logic [3:0] w0; logic [BW-1:0] b0; int bad;
    drive_beat(4'd0, 17'd5, 1'b0);
    drive_beat(4'd6, 17'd77, 1'b1);
    get_result(ok);
    e = sb.pop_front();
    checks += 3;
    if (!ok) begin errors++; $display("FAIL bp_valid: out_valid=%0b required 1", out_valid); end
    if (out_winner !== e.w) begin errors++; $display("FAIL bp_winner: got %0d required %0d", out_winner, e.w); end
    if (out_bid !== e.b) begin errors++; $display("FAIL bp_bid: got %0d required %0d", out_bid, e.b); end
    w0 = out_winner; b0 = out_bid;
    in_valid = 1'b1; in_id = 4'd0; in_bid = 17'd123; in_last = 1'b1;
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_winner !== w0 || out_bid !== b0 || in_ready !== 1'b0 || bids[0] !== 17'd5) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL bp_stable: %0d unstable cycles, required 0", bad); end
    in_valid = 1'b0; in_last = 1'b0;
    ack();
    checks += 3;
    if (bids[0] !== '0 || bids[6] !== '0) begin errors++; $display("FAIL bp_clear: bids0=%0d bids6=%0d required 0", bids[0], bids[6]); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready: got %0b required 1", in_ready); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drop: out_valid=%0b required 0", out_valid); end
    drive_beat(4'd0, 17'd123, 1'b1);
    get_result(ok);
    e = sb.pop_front();
    checks += 2;
    if (out_winner !== e.w) begin errors++; $display("FAIL bp_next_winner: got %0d required %0d", out_winner, e.w); end
    if (out_bid !== e.b) begin errors++; $display("FAIL bp_next_bid: got %0d required %0d", out_bid, e.b); end
    ack();
  endtask

  task automatic test_reset_mid();
    exp_t e; bit ok; int bad;
    drive_beat(4'd3, 17'd80, 1'b1);
    void'(sb.pop_back());
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      if (out_valid !== 1'b0 || bids[3] !== '0 || out_winner !== '0 || out_bid !== '0 || out_err !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL rstmid_abort: %0d cycles not at reset values, required 0", bad); end
    drive_beat(4'd4, 17'd5, 1'b1);
    get_result(ok);
    e = sb.pop_front();
    checks += 2;
    if (!ok) begin errors++; $display("FAIL rstmid_valid: out_valid=%0b required 1", out_valid); end
    if (out_winner !== e.w) begin errors++; $display("FAIL rstmid_winner: got %0d required %0d", out_winner, e.w); end
    ack();
  endtask

  task automatic test_back_to_back();
    exp_t e; bit ok;
    int k, prev_k, start, prev_start;
    prev_k = 0; prev_start = 0;
    out_ready = 1'b1;
    for (int r = 0; r < 5; r++) begin
      k = $urandom_range(1, 5);
      for (int j = 0; j < k; j++) begin
        drive_beat(4'($urandom_range(0, 9)), 17'($urandom_range(0, 1000)), j == k - 1);
        if (j == 0) start = acc_cyc;
      end
      get_result(ok);
      e = sb.pop_front();
      checks += 4;
      if (!ok) begin errors++; $display("FAIL b2b_valid r%0d: out_valid=%0b required 1", r, out_valid); end
      if (out_winner !== e.w) begin errors++; $display("FAIL b2b_winner r%0d: got %0d required %0d", r, out_winner, e.w); end
      if (out_bid !== e.b) begin errors++; $display("FAIL b2b_bid r%0d: got %0d required %0d", r, out_bid, e.b); end
      if (out_err !== e.e) begin errors++; $display("FAIL b2b_err r%0d: got %0b required %0b", r, out_err, e.e); end
      if (r > 0) begin
        checks++;
        if (start - prev_start != prev_k + 3)
          begin errors++; $display("FAIL b2b_rate r%0d: round took %0d cycles required %0d", r, start - prev_start, prev_k + 3); end
      end
      prev_k = k; prev_start = start;
    end
    @(negedge clk);
    out_ready = 1'b0;
  endtask

`ifdef BID_RESERVE_EN
  task automatic test_reserve();
    exp_t e; bit ok;
    drive_beat(4'd0, 17'd15, 1'b0);
    drive_beat(4'd5, 17'd16, 1'b1);
    get_result(ok);
    e = sb.pop_front();
    checks += 3;
    if (out_winner !== e.w) begin errors++; $display("FAIL res_winner: got %0d required %0d", out_winner, e.w); end
    if (out_bid !== e.b) begin errors++; $display("FAIL res_bid: got %0d required %0d", out_bid, e.b); end
    if (out_none !== e.n) begin errors++; $display("FAIL res_none: got %0b required %0b", out_none, e.n); end
    ack();
    drive_beat(4'd0, 17'd15, 1'b1);
    get_result(ok);
    e = sb.pop_front();
    checks += 2;
    if (out_bid !== e.b) begin errors++; $display("FAIL res_none_bid: got %0d required %0d", out_bid, e.b); end
    if (out_none !== e.n) begin errors++; $display("FAIL res_none_flag: got %0b required %0b", out_none, e.n); end
    ack();
  endtask
`endif

  initial begin
    model_clear();
    @(negedge clk);
    test_reset();
    test_basic();
    test_duplicate();
    test_illegal();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
`ifdef BID_RESERVE_EN
    test_reserve();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bid_assembler.md
# bid_assembler

Upstream feeder for the 10-way argmax winner stage. Collects one auction round of bids from a serial valid/ready stream, holds them in a 10-entry register array that drives the argmax `bids` inputs, and waits out the argmax pipeline latency. It then captures the winner index plus the winning bid, and presents both downstream with a valid/ready handshake.

## Interface
- `bW`, 17: bid width in bits; must match the argmax stage.
- `RESERVE`, 0: reserve price. Used only when `BID_RESERVE_EN` is defined.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset. The argmax stage is fed `~rst` on its `rst_n`.
- `in_valid`  in  1  bid beat valid.
- `in_ready`  out  1  block accepts a beat this cycle.
- `in_id`  in  4  bidder index; legal range 0–9.
- `in_bid`  in  bW  bid value, unsigned.
- `in_last`  in  1  final beat of the round.
- `bids[0:9]`  out  bW each  registered bid array to the argmax stage.
- `win_in`  in  4  winner index from the argmax stage (registered there, 1-cycle latency).
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts the result.
- `out_winner`  out  4  captured winner index.
- `out_bid`  out  bW  `bids[out_winner]` at capture time.
- `out_err`  out  1  round contained an illegal id or a duplicate id.
- `out_none`  out  1  no bid met the reserve. Tied to 0 without `BID_RESERVE_EN`.

## Operation
- **States:** COLLECT, SETTLE, PRESENT. Reset state is COLLECT.
- **COLLECT**
  - `in_ready` = 1.
  - Beat accepted when `in_valid && in_ready`.
  - With `in_id` ≤ 9, the entry updates to `max(stored, in_bid)`, so a duplicate id keeps the larger bid.
  - A second beat to an already-written id sets the `err` flag.
  - `in_id` ≥ 10: bid discarded, `err` flag set.
  - A per-id 10-bit received mask tracks which ids have been written.
  - Entries never written in the round stay 0.
  - Accepted beat with `in_last` = 1 moves the block to SETTLE, and the settle counter loads 1. The beat's own bid is still written.
- **SETTLE**
  - `in_ready` = 0.
  - Cycle 1: `bids` are stable and the argmax stage samples them.
  - Cycle 2: `win_in` is valid. `out_winner` ← `win_in`, `out_bid` ← `bids[win_in]`, `out_err` ← `err` flag, `out_none` computed. Go to PRESENT.
- **PRESENT**
  - `in_ready` = 0.
  - `out_valid` = 1, and `out_*` held stable until `out_ready`.
  - On handshake: array, mask, and `err` clear to 0; `out_valid` drops; go to COLLECT.
- **Arithmetic:** all comparisons unsigned, bW bits. No saturation is needed because values are stored, never summed.
- **Ties:** `out_winner` is exactly what the argmax stage reports. `out_bid` equals the tied value.

## Timing
- **Reset values:**
  - `in_ready` = 0 while `rst` is high; it reads 1 the first cycle after `rst` falls.
  - `bids` = all 0, `out_valid` = 0, `out_winner` = 0, `out_bid` = 0, `out_err` = 0, `out_none` = 0.
- **Latency:**
  - Last beat accepted at edge E0 → `out_valid` high after edge E2.
  - Earliest next beat accepted on the cycle after the `out_ready` handshake.
- **Throughput:** one round per (beats + 3) cycles with `out_ready` held high.
- **Handshake rules:**
  - `out_valid` must not drop and `out_*` must not change before `out_ready`.
  - `in_ready` is a pure function of state, with no dependence on `in_valid`.
- **Reset mid-round:** reset in any state aborts the round with no output. The partial array is discarded and the block returns to COLLECT with the reset values above.
- **Backpressure:** `in_valid` asserted in SETTLE or PRESENT is ignored (not accepted, no state change).

## Configuration
- **`BID_RESERVE_EN` defined:**
  - Accepted bids with `in_bid < RESERVE` are stored as 0 and still mark the id as received.
  - `out_none` = 1 when all 10 entries are 0 at capture. `out_winner` still carries `win_in`, and `out_bid` = 0.
- **Not defined:**
  - No reserve logic; `RESERVE` is unused.
  - `out_none` is constant 0.

## Test plan
- Beats (id 0, 10), (1, 40), (2, 25, last) → after 2 cycles `out_valid` = 1, `out_winner` = 1, `out_bid` = 40, `out_err` = 0.
- Beats (9, 7), (9, 30, last) → `bids[9]` = 30, `out_winner` = 9, `out_bid` = 30, `out_err` = 1. Then (9, 50), (9, 20, last) in the next round → `bids[9]` = 50 and `out_bid` = 50, proving the larger duplicate is kept.
- Beat (12, 99, last) → all bids 0, `out_err` = 1, `out_bid` = 0.
- Result presented with `out_ready` = 0 for 5 cycles while `in_valid` = 1 → `out_*` stable, no beat accepted. Raise `out_ready` → next beat accepted one cycle later, array cleared first.
- `rst` pulsed during SETTLE after beats (3, 80, last) → no `out_valid`; all outputs at reset values. The next round (4, 5, last) yields `out_winner` = 4.
- With `BID_RESERVE_EN`, `RESERVE` = 16: beats (0, 15), (5, 16, last) → `out_winner` = 5, `out_bid` = 16, `out_none` = 0. Beats (0, 15, last) alone → `out_none` = 1, `out_bid` = 0.
